// File: rtl/csr_pkg.sv
// Shared CSR definitions: address map, Zicsr funct3 encodings and data word type.
package csr_pkg;

    localparam int CSR_XLEN = 32;

    typedef logic [CSR_XLEN-1:0] csr_word_t;

    localparam logic [11:0] SCRATCH_BASE   = 12'h340;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    typedef enum logic [2:0] {
        OP_RW  = 3'b001,
        OP_RS  = 3'b010,
        OP_RC  = 3'b011,
        OP_RWI = 3'b101,
        OP_RSI = 3'b110,
        OP_RCI = 3'b111
    } csr_op_e;

endpackage

// File: rtl/csr_file_counter64.sv
// 64-bit counter with half-word write ports; a write blocks that edge's increment.
module csr_counter64
    import csr_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        incEn,
    input  logic        wrLo,
    input  logic        wrHi,
    input  csr_word_t   wdata,
    output logic [63:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= '0;
        end else if (wrLo || wrHi) begin
            if (wrLo) value[31:0]  <= wdata;
            if (wrHi) value[63:32] <= wdata;
        end else if (incEn) begin
            value <= value + 64'd1;
        end
    end

endmodule

// File: rtl/csr_file.sv
// Zicsr register file: scratch CSRs, tohost with strobe, optional counters.
// Counters are built only when CSR_COUNTERS_EN is defined.
module csr_file
    import csr_pkg::*;
#(
    parameter int          XLEN        = 32,
    parameter int          NUM_SCRATCH = 4,
    parameter logic [11:0] TOHOST_ADDR = 12'h51E
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_valid,
    input  logic            stall,
    input  logic            flush,
    input  logic [2:0]      csr_funct3,
    input  logic [11:0]     csr_addr,
    input  logic [4:0]      csr_rs1_idx,
    input  logic [XLEN-1:0] csr_wsrc,
    input  logic            retire,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_rdata_valid,
    output logic            csr_illegal,
    output logic [XLEN-1:0] tohost,
    output logic            tohost_strobe
);

    logic                   accept;
    logic                   opOk;
    logic                   wrReq;
    logic                   hit;
    logic                   readOnly;
    logic                   illegal;
    logic                   doWrite;
    logic                   tohostSel;
    logic [NUM_SCRATCH-1:0] scrSel;
    csr_word_t              operand;
    csr_word_t              oldVal;
    csr_word_t              newVal;
    csr_word_t              scratchQ [NUM_SCRATCH];

    assign accept  = csr_valid & ~stall & ~flush;
    assign opOk    = csr_funct3[1:0] != 2'b00;
    assign wrReq   = (csr_funct3[1:0] == 2'b01) | (csr_rs1_idx != 5'd0);
    assign operand = csr_funct3[2] ? {{(CSR_XLEN-5){1'b0}}, csr_rs1_idx}
                                   : csr_wsrc;

`ifdef CSR_COUNTERS_EN
    logic        cycLoSel;
    logic        cycHiSel;
    logic        insLoSel;
    logic        insHiSel;
    logic [63:0] cycVal;
    logic [63:0] insVal;
`else
    logic        unusedRetire;
    assign unusedRetire = retire;
`endif

    always_comb begin
        oldVal    = '0;
        hit       = 1'b0;
        readOnly  = 1'b0;
        tohostSel = 1'b0;
        scrSel    = '0;
`ifdef CSR_COUNTERS_EN
        cycLoSel  = 1'b0;
        cycHiSel  = 1'b0;
        insLoSel  = 1'b0;
        insHiSel  = 1'b0;
`endif
        for (int i = 0; i < NUM_SCRATCH; i++) begin
            if (csr_addr == SCRATCH_BASE + 12'(i)) begin
                scrSel[i] = 1'b1;
                hit       = 1'b1;
                oldVal    = scratchQ[i];
            end
        end
        if (csr_addr == TOHOST_ADDR) begin
            tohostSel = 1'b1;
            hit       = 1'b1;
            oldVal    = tohost;
        end
`ifdef CSR_COUNTERS_EN
        // user-level aliases at 0xCxx share the machine counters but are read-only
        unique case (csr_addr)
            ADDR_MCYCLE, ADDR_CYCLE: begin
                hit      = 1'b1;
                cycLoSel = 1'b1;
                oldVal   = cycVal[31:0];
            end
            ADDR_MCYCLEH, ADDR_CYCLEH: begin
                hit      = 1'b1;
                cycHiSel = 1'b1;
                oldVal   = cycVal[63:32];
            end
            ADDR_MINSTRET, ADDR_INSTRET: begin
                hit      = 1'b1;
                insLoSel = 1'b1;
                oldVal   = insVal[31:0];
            end
            ADDR_MINSTRETH, ADDR_INSTRETH: begin
                hit      = 1'b1;
                insHiSel = 1'b1;
                oldVal   = insVal[63:32];
            end
            default: ;
        endcase
        readOnly = hit & (csr_addr[11:10] == 2'b11);
`endif
    end

    always_comb begin
        newVal = oldVal;
        case (csr_op_e'(csr_funct3))
            OP_RW, OP_RWI: newVal = operand;
            OP_RS, OP_RSI: newVal = oldVal | operand;
            OP_RC, OP_RCI: newVal = oldVal & ~operand;
            default:       newVal = oldVal;
        endcase
    end

    assign illegal = ~opOk | ~hit | (readOnly & wrReq);
    assign doWrite = accept & ~illegal & wrReq;

`ifdef CSR_COUNTERS_EN
    csr_counter64 uCycle (
        .clk   (clk),
        .rst   (rst),
        .incEn (1'b1),
        .wrLo  (doWrite & cycLoSel),
        .wrHi  (doWrite & cycHiSel),
        .wdata (newVal),
        .value (cycVal)
    );

    csr_counter64 uInstret (
        .clk   (clk),
        .rst   (rst),
        .incEn (retire),
        .wrLo  (doWrite & insLoSel),
        .wrHi  (doWrite & insHiSel),
        .wdata (newVal),
        .value (insVal)
    );
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SCRATCH; i++) scratchQ[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (doWrite && scrSel[i]) scratchQ[i] <= newVal;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tohost          <= '0;
            tohost_strobe   <= 1'b0;
            csr_rdata       <= '0;
            csr_rdata_valid <= 1'b0;
            csr_illegal     <= 1'b0;
        end else begin
            tohost_strobe   <= doWrite & tohostSel & (newVal != '0);
            if (doWrite && tohostSel) tohost <= newVal;
            csr_rdata_valid <= accept;
            csr_illegal     <= accept & illegal;
            if (accept) csr_rdata <= illegal ? '0 : oldVal;
        end
    end

endmodule

// File: tb/tb_csr_file.sv
// Scoreboard bench for csr_file: directed accesses, monitor pops expected responses.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csr_valid;
    logic        stall;
    logic        flush;
    logic [2:0]  csr_funct3;
    logic [11:0] csr_addr;
    logic [4:0]  csr_rs1_idx;
    logic [31:0] csr_wsrc;
    logic        retire;
    logic [31:0] csr_rdata;
    logic        csr_rdata_valid;
    logic        csr_illegal;
    logic [31:0] tohost;
    logic        tohost_strobe;

    localparam logic [2:0] RW  = 3'b001;
    localparam logic [2:0] RS  = 3'b010;
    localparam logic [2:0] RC  = 3'b011;
    localparam logic [2:0] RSI = 3'b110;
    localparam logic [2:0] RCI = 3'b111;

    typedef struct {
        logic [31:0] rdata;
        logic        ill;
        string       name;
    } exp_t;

    exp_t expQ[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;

    csr_file dut (
        .clk             (clk),
        .rst             (rst),
        .csr_valid       (csr_valid),
        .stall           (stall),
        .flush           (flush),
        .csr_funct3      (csr_funct3),
        .csr_addr        (csr_addr),
        .csr_rs1_idx     (csr_rs1_idx),
        .csr_wsrc        (csr_wsrc),
        .retire          (retire),
        .csr_rdata       (csr_rdata),
        .csr_rdata_valid (csr_rdata_valid),
        .csr_illegal     (csr_illegal),
        .tohost          (tohost),
        .tohost_strobe   (tohost_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setReq(input logic [2:0] f3, input logic [11:0] addr,
                          input logic [4:0] rs1, input logic [31:0] wsrc);
        csr_funct3  = f3;
        csr_addr    = addr;
        csr_rs1_idx = rs1;
        csr_wsrc    = wsrc;
    endtask

    task automatic access(input string name, input logic [2:0] f3,
                          input logic [11:0] addr, input logic [4:0] rs1,
                          input logic [31:0] wsrc, input logic [31:0] expRd,
                          input logic expIll);
        exp_t x;
        setReq(f3, addr, rs1, wsrc);
        csr_valid = 1'b1;
        x.rdata = expRd;
        x.ill   = expIll;
        x.name  = name;
        expQ.push_back(x);
        @(negedge clk);
        csr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (!rst && csr_rdata_valid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got rdata %h expected no response",
                         csr_rdata);
            end else begin
                e = expQ.pop_front();
                check({e.name, "_rdata"}, csr_rdata, e.rdata);
                check({e.name, "_illegal"}, 32'(csr_illegal), 32'(e.ill));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        csr_valid = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        retire    = 1'b0;
        setReq(3'b000, 12'h000, 5'd0, 32'h0);
        repeat (2) @(negedge clk);
        check("rst_rdata", csr_rdata, 32'h0);
        check("rst_valid", 32'(csr_rdata_valid), 32'h0);
        check("rst_illegal", 32'(csr_illegal), 32'h0);
        check("rst_tohost", tohost, 32'h0);
        check("rst_strobe", 32'(tohost_strobe), 32'h0);
        rst = 1'b0;

`ifdef CSR_COUNTERS_EN
        idle(10);
        access("cyc10", RS, 12'hC00, 5'd0, 32'h0, 32'd10, 1'b0);
        access("mcyc_wr", RW, 12'hB00, 5'd1, 32'hFFFF_FFFF, 32'd11, 1'b0);
        idle(1);
        access("mcyc_carry", RS, 12'hB80, 5'd0, 32'h0, 32'd1, 1'b0);
        access("cych_alias", RS, 12'hC80, 5'd0, 32'h0, 32'd1, 1'b0);
        access("mcyc_wr100", RW, 12'hB00, 5'd1, 32'd100, 32'd2, 1'b0);
        access("cyc_ro_wr", RW, 12'hC00, 5'd1, 32'h0, 32'h0, 1'b1);
        access("mcyc_after", RS, 12'hB00, 5'd0, 32'h0, 32'd101, 1'b0);
        retire = 1'b1;
        idle(3);
        access("minst_wr", RW, 12'hB02, 5'd1, 32'd50, 32'd3, 1'b0);
        retire = 1'b0;
        access("minst_rd", RS, 12'hC02, 5'd0, 32'h0, 32'd50, 1'b0);
`else
        access("nocnt_b00", RS, 12'hB00, 5'd0, 32'h0, 32'h0, 1'b1);
        access("nocnt_c00", RW, 12'hC00, 5'd1, 32'h5, 32'h0, 1'b1);
`endif

        access("s0_rw", RW, 12'h340, 5'd1, 32'hDEAD_BEEF, 32'h0, 1'b0);
        access("s0_rs0", RS, 12'h340, 5'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0);
        access("s0_rs0b", RS, 12'h340, 5'd0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        access("s1_rsi", RSI, 12'h341, 5'd5, 32'h0, 32'h0, 1'b0);
        access("s1_rci", RCI, 12'h341, 5'd1, 32'h0, 32'h5, 1'b0);
        access("s1_rd", RS, 12'h341, 5'd0, 32'h0, 32'h4, 1'b0);
        access("s0_rc", RC, 12'h340, 5'd3, 32'h0000_FFFF, 32'hDEAD_BEEF, 1'b0);
        access("s0_rd", RS, 12'h340, 5'd0, 32'h0, 32'hDEAD_0000, 1'b0);
        access("s3_rw", RW, 12'h343, 5'd1, 32'h1234_5678, 32'h0, 1'b0);
        access("s4_unmap", RW, 12'h344, 5'd1, 32'h1, 32'h0, 1'b1);
        access("s3_rd", RS, 12'h343, 5'd0, 32'h0, 32'h1234_5678, 1'b0);
        access("f3_000", 3'b000, 12'h340, 5'd1, 32'h0, 32'h0, 1'b1);
        access("f3_100", 3'b100, 12'h340, 5'd1, 32'h0, 32'h0, 1'b1);
        access("s0_keep", RS, 12'h340, 5'd0, 32'h0, 32'hDEAD_0000, 1'b0);

        access("th_wr1", RW, 12'h51E, 5'd1, 32'h1, 32'h0, 1'b0);
        check("th_strobe1", 32'(tohost_strobe), 32'h1);
        check("th_val1", tohost, 32'h1);
        idle(1);
        check("th_strobe_end", 32'(tohost_strobe), 32'h0);
        access("th_wr0", RW, 12'h51E, 5'd1, 32'h0, 32'h1, 1'b0);
        check("th_strobe0", 32'(tohost_strobe), 32'h0);
        check("th_val0", tohost, 32'h0);
        idle(1);
        check("hold_valid", 32'(csr_rdata_valid), 32'h0);
        check("hold_rdata", csr_rdata, 32'h1);
        check("hold_illegal", 32'(csr_illegal), 32'h0);

        setReq(RW, 12'h342, 5'd1, 32'h0000_00A5);
        csr_valid = 1'b1;
        stall     = 1'b1;
        idle(3);
        stall = 1'b0;
        e.rdata = 32'h0;
        e.ill   = 1'b0;
        e.name  = "stall_rel";
        expQ.push_back(e);
        @(negedge clk);
        csr_valid = 1'b0;
        setReq(RW, 12'h342, 5'd1, 32'h0000_005A);
        csr_valid = 1'b1;
        flush     = 1'b1;
        idle(2);
        flush     = 1'b0;
        csr_valid = 1'b0;
        access("s2_rd", RS, 12'h342, 5'd0, 32'h0, 32'h0000_00A5, 1'b0);

        access("th_wr5", RW, 12'h51E, 5'd1, 32'h5, 32'h0, 1'b0);
        access("th_wr7", RW, 12'h51E, 5'd1, 32'h7, 32'h5, 1'b0);
        setReq(RW, 12'h341, 5'd1, 32'h99);
        csr_valid = 1'b1;
        #1 rst = 1'b1;
        #2;
        check("mid_rst_rdata", csr_rdata, 32'h0);
        check("mid_rst_valid", 32'(csr_rdata_valid), 32'h0);
        check("mid_rst_illegal", 32'(csr_illegal), 32'h0);
        check("mid_rst_tohost", tohost, 32'h0);
        check("mid_rst_strobe", 32'(tohost_strobe), 32'h0);
        @(negedge clk);
        csr_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        access("post_s0", RS, 12'h340, 5'd0, 32'h0, 32'h0, 1'b0);
        access("post_s1", RS, 12'h341, 5'd0, 32'h0, 32'h0, 1'b0);
        access("post_th", RS, 12'h51E, 5'd0, 32'h0, 32'h0, 1'b0);

        for (int i = 0; i < 10 && expQ.size() != 0; i++) @(negedge clk);
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses expected 0",
                     expQ.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
